eth_reset_sequencer: RTL
========================

// Module: eth_reset_sequencer
// PURPOSE
//  Parametrised reset sequencer for the Ethernet controller subsystem; successor to the single fixed-depth sync chain.
//  Holds channels_p downstream reset domains in reset, releases them in ascending index order, and waits on each one's ready.
//  Each ready is e.g. IDELAYCTRL rdy, MMCM lock or MAC init done; an inter-channel gap separates consecutive releases.
//  Per-channel timeout reporting, software-requested re-sequencing and (optional) ready-loss monitoring are included.
// PARAMETERS
//  channels_p        4     number of sequenced reset domains (>=1)
//  sync_depth_p      4     flops in each ready_i synchroniser chain (>=2)
//  stretch_cycles_p  16    cycles all resets are held after entry to ASSERT (>=1)
//  gap_cycles_p      8     cycles between channel i ready and channel i+1 release (>=1)
//  timeout_cycles_p  1024  max WAIT cycles per channel before timeout (>=1)
// PORTS
//  clk_i        in   1           single clock, all logic
//  reset_n_i    in   1           asynchronous, active-low reset
//  sw_reset_i   in   1           sync level/pulse: restart whole sequence
//  ready_i      in   channels_p  per-channel ready, asynchronous, synchronised internally
//  reset_o      out  channels_p  per-channel reset, active-high
//  done_o       out  1           all channels released and sequence complete
//  timeout_o    out  channels_p  sticky: channel i timed out in WAIT
//  busy_o       out  1           sequencer not in DONE
// BEHAVIOUR
//  - Reset values (reset_n_i low): reset_o='1, done_o=0, timeout_o='0, busy_o=1.
//    State=ASSERT, counter=0, channel index=0, sync chains=0.
//  - Reset deassertion is async-assert only; no reset_o bit changes in the clk_i edge where reset_n_i deasserts.
//  - ready_i[i] passes through sync_depth_p flops; rdy_s[i] is the final stage. Latency = sync_depth_p cycles.
//  - Counter width $clog2(max(stretch,gap,timeout)+1); counts up from 0 and clears on every state entry.
//  - FSM:
//    ASSERT: reset_o='1. After stretch_cycles_p cycles -> WAIT, idx=0, reset_o[0] low from the first WAIT cycle.
//    WAIT(idx): reset_o[0..idx]=0.
//      If rdy_s[idx]=1 -> GAP, or DONE when idx==channels_p-1.
//      Else if counter reaches timeout_cycles_p-1 -> set timeout_o[idx], then same exit as the ready path.
//    GAP: held gap_cycles_p cycles. Then idx+=1 -> WAIT; reset_o[idx] drops on WAIT entry.
//    DONE: done_o=1, busy_o=0, reset_o='0; stays until sw_reset_i or ready loss (see CONFIGURATION).
//  - Ready already high at WAIT entry: WAIT lasts exactly 1 cycle.
//  - A timed-out channel keeps its reset_o deasserted; the sequence continues and done_o still asserts.
//  - sw_reset_i=1 in any state (incl. ASSERT) at a clock edge: next state ASSERT.
//    On that edge: reset_o='1, counter=0, idx=0, timeout_o='0, done_o=0.
//    Takes priority over every other transition in the same cycle.
//    If held high, the sequencer stays in ASSERT with the counter held at 0.
//  - reset_n_i asserted mid-sequence: immediate return to reset values (async).
//  - channels_p=1: ASSERT -> WAIT(0) -> DONE, no GAP state visited.
// CONFIGURATION
//  ETH_RST_SEQ_READY_MON_EN defined:
//    In DONE, any rdy_s[i]=0 for a channel without timeout_o[i] set -> ASSERT, as for sw_reset_i.
//    The difference from sw_reset_i: timeout_o is preserved.
//  ETH_RST_SEQ_READY_MON_EN undefined:
//    DONE ignores ready_i entirely; only sw_reset_i or reset_n_i leave DONE.
// TESTING
//  1 Defaults, all ready_i tied 1 from t0.
//    -> reset_o[0] falls 16 cycles after reset_n_i release.
//    -> Each later channel falls 1+8 cycles after the previous one.
//    -> done_o rises the cycle after WAIT(3); timeout_o=0.
//  2 ready_i[1] held 0, others 1, timeout_cycles_p=32.
//    -> timeout_o=4'b0010 after exactly 32 WAIT(1) cycles.
//    -> reset_o[2], reset_o[3] still release; done_o=1.
//  3 ready_i[2] rises 20 cycles into WAIT(2).
//    -> exit WAIT 20+sync_depth_p cycles after entry; reset_o[3] falls 8 cycles later.
//  4 sw_reset_i 1-cycle pulse during GAP after channel 1, and again during DONE with timeout_o set.
//    -> reset_o=4'b1111 next cycle, timeout_o cleared, full sequence repeats.
//  5 sw_reset_i and rdy_s[idx] both high in the same WAIT cycle.
//    -> ASSERT wins; no GAP entry.
//  6 MON_EN build: drop ready_i[0] in DONE -> ASSERT after sync_depth_p+1 cycles.
//    Non-MON_EN build: same stimulus -> done_o stays 1.
//    reset_n_i pulse low mid-WAIT -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/eth_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : eth_reset_sequencer
// Purpose  : Releases channels_p reset domains in ascending order, waiting on
//            each domain's synchronised ready, with per-channel timeouts and
//            software restart. Optional build macro ETH_RST_SEQ_READY_MON_EN
//            enables ready-loss monitoring in DONE.
// Revision : 1.0 - initial release
// ============================================================================
module eth_reset_sequencer #(
   parameter int channels_p       = 4,
   parameter int sync_depth_p     = 4,
   parameter int stretch_cycles_p = 16,
   parameter int gap_cycles_p     = 8,
   parameter int timeout_cycles_p = 1024
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  sw_reset_i,
   input  logic [channels_p-1:0] ready_i,
   output logic [channels_p-1:0] reset_o,
   output logic                  done_o,
   output logic [channels_p-1:0] timeout_o,
   output logic                  busy_o
);

   localparam int c_max_sg  = (stretch_cycles_p > gap_cycles_p) ? stretch_cycles_p : gap_cycles_p;
   localparam int c_cnt_max = (c_max_sg > timeout_cycles_p) ? c_max_sg : timeout_cycles_p;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
   localparam int c_idx_w   = (channels_p > 1) ? $clog2(channels_p) : 1;

   localparam logic [c_cnt_w-1:0] c_stretch_last = c_cnt_w'(stretch_cycles_p - 1);
   localparam logic [c_cnt_w-1:0] c_gap_last     = c_cnt_w'(gap_cycles_p - 1);
   localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(timeout_cycles_p - 1);
   localparam logic [c_idx_w-1:0] c_last_idx     = c_idx_w'(channels_p - 1);

   typedef enum logic [1:0] {
      ST_ASSERT = 2'd0,
      ST_WAIT   = 2'd1,
      ST_GAP    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                                   r_state;
   state_t                                   w_state_nx;
   logic [c_cnt_w-1:0]                       r_cnt;
   logic [c_cnt_w-1:0]                       w_cnt_nx;
   logic [c_idx_w-1:0]                       r_idx;
   logic [c_idx_w-1:0]                       w_idx_nx;
   logic [sync_depth_p-1:0][channels_p-1:0]  r_sync;
   logic [channels_p-1:0]                    w_rdy_s;
   logic                                     w_rdy_cur;
   logic [channels_p-1:0]                    r_reset;
   logic [channels_p-1:0]                    w_rst_nx;
   logic [channels_p-1:0]                    r_timeout;
   logic [channels_p-1:0]                    w_to_nx;
   logic                                     r_done;
   logic                                     r_busy;

   // Ready inputs are fully asynchronous; stage 0 takes ready_i directly.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[sync_depth_p-2:0], ready_i};
      end
   end

   assign w_rdy_s   = r_sync[sync_depth_p-1];
   assign w_rdy_cur = w_rdy_s[r_idx];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state   <= ST_ASSERT;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_reset   <= '1;
         r_timeout <= '0;
         r_done    <= 1'b0;
         r_busy    <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_idx     <= w_idx_nx;
         r_reset   <= w_rst_nx;
         r_timeout <= w_to_nx;
         r_done    <= (w_state_nx == ST_DONE);
         r_busy    <= (w_state_nx != ST_DONE);
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + c_cnt_w'(1);
      w_idx_nx   = r_idx;
      w_to_nx    = r_timeout;
      case (r_state)
         ST_ASSERT: begin
            if (r_cnt == c_stretch_last) begin
               w_state_nx = ST_WAIT;
               w_idx_nx   = '0;
               w_cnt_nx   = '0;
            end
         end
         ST_WAIT: begin
            // A timed-out channel exits exactly like a ready one; only the flag differs.
            if (w_rdy_cur || (r_cnt == c_timeout_last)) begin
               if (!w_rdy_cur) begin
                  w_to_nx[r_idx] = 1'b1;
               end
               w_cnt_nx   = '0;
               w_state_nx = (r_idx == c_last_idx) ? ST_DONE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (r_cnt == c_gap_last) begin
               w_state_nx = ST_WAIT;
               w_idx_nx   = r_idx + c_idx_w'(1);
               w_cnt_nx   = '0;
            end
         end
         ST_DONE: begin
            w_cnt_nx = '0;
`ifdef ETH_RST_SEQ_READY_MON_EN
            // Channels that already timed out are not expected to hold ready.
            if (|(~w_rdy_s & ~r_timeout)) begin
               w_state_nx = ST_ASSERT;
               w_idx_nx   = '0;
            end
`else
            w_state_nx = ST_DONE;
`endif
         end
         default: begin
            w_state_nx = ST_ASSERT;
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
         end
      endcase
      if (sw_reset_i) begin
         w_state_nx = ST_ASSERT;
         w_cnt_nx   = '0;
         w_idx_nx   = '0;
         w_to_nx    = '0;
      end
   end

   // Outputs are registered from the next state so they never glitch.
   always_comb begin
      w_rst_nx = '1;
      for (int c = 0; c < channels_p; c++) begin
         if (w_state_nx == ST_DONE) begin
            w_rst_nx[c] = 1'b0;
         end else if ((w_state_nx != ST_ASSERT) && (c_idx_w'(c) <= w_idx_nx)) begin
            w_rst_nx[c] = 1'b0;
         end
      end
   end

   assign reset_o   = r_reset;
   assign timeout_o = r_timeout;
   assign done_o    = r_done;
   assign busy_o    = r_busy;

endmodule
`default_nettype wire
